// File: rtl/ca_pkg.sv
// Shared types and index helpers for the cellular-automaton generation scheduler.
// Edge handling of the rule row is selected by CA_WRAP_EN.
package ca_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WRITE
  } ca_state_e;

  localparam int CA_ROWS = 60;
  localparam int PTR_W   = $clog2(CA_ROWS);

  // Modular add for operands already in 0..rows-1, no divider.
  function automatic int mod_add(int a, int b, int rows);
    int s;
    s = a + b;
    return (s >= rows) ? s - rows : s;
  endfunction

  function automatic int mod_inc(int a, int rows);
    return (a == rows - 1) ? 0 : a + 1;
  endfunction

  // Window is {left, centre, right}.
  function automatic logic rule_bit(logic [7:0] rule,
                                    logic [2:0] win);
    return rule[win];
  endfunction

endpackage

// File: rtl/ca_rule_row.sv
// One combinational generation step of a 1-D Wolfram-rule automaton.
// CA_WRAP_EN selects toroidal edges; otherwise out-of-range cells read 0.
module ca_rule_row
  import ca_pkg::*;
#(
  parameter int         WIDTH = 80,
  parameter logic [7:0] RULE  = 8'd30
) (
  input  logic [WIDTH-1:0] row,
  output logic [WIDTH-1:0] next_row
);

  logic [WIDTH+1:0] ext;

  always_comb begin
`ifdef CA_WRAP_EN
    ext = {row[0], row, row[WIDTH-1]};
`else
    ext = {1'b0, row, 1'b0};
`endif
    next_row = '0;
    for (int i = 0; i < WIDTH; i++) begin
      next_row[i] = rule_bit(RULE, ext[i +: 3]);
    end
  end

endmodule

// File: rtl/ca_gen_scheduler.sv
// Ring buffer of CA generations with a blanking-time update FSM and scrolling read port.
// Build option CA_WRAP_EN selects toroidal row edges in ca_rule_row.
module ca_gen_scheduler
  import ca_pkg::*;
#(
  parameter int               WIDTH          = 80,
  parameter int               ROWS           = CA_ROWS,
  parameter logic [7:0]       RULE           = 8'd30,
  parameter logic [WIDTH-1:0] SEED           = WIDTH'(1) << 40,
  parameter int               FRAMES_PER_GEN = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     frame_tick,
  input  logic                     run,
  input  logic                     step,
  input  logic [$clog2(ROWS)-1:0]  rd_row,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     busy,
  output logic                     overrun,
  output logic [15:0]              gen_count
);

  localparam int AW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + 1);
  localparam int FW = (FRAMES_PER_GEN > 1) ?
                      $clog2(FRAMES_PER_GEN) : 1;

  ca_state_e        state;
  logic [AW-1:0]    head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    phys;
  logic [AW-1:0]    wa;
  logic [CW-1:0]    filled;
  logic [FW-1:0]    frame_cnt;
  logic [WIDTH-1:0] cur_row;
  logic [WIDTH-1:0] next_row;
  logic [WIDTH-1:0] calc_row;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] mem [ROWS];
  logic             seed_pend;
  logic             full;
  logic             frame_last;
  logic             start;
  logic             rd_ok;
  logic             we;
  int               ofs;

  assign full       = (filled == CW'(ROWS));
  assign frame_last = (frame_cnt == FW'(FRAMES_PER_GEN - 1));
  assign start      = step | (run & frame_tick & frame_last);

  // Newest generation is always shown at rd_row = ROWS-1.
  always_comb begin
    wr_ptr = full ? head :
             AW'(mod_add(int'(head), int'(filled), ROWS));
    ofs    = int'(rd_row) + int'(filled) - ROWS;
    rd_ok  = (int'(rd_row) < ROWS) && (ofs >= 0);
    phys   = '0;
    if (rd_ok) begin
      phys = AW'(mod_add(int'(head), ofs, ROWS));
    end
    we = seed_pend | (state == WRITE);
    wa = seed_pend ? '0 : wr_ptr;
    wd = seed_pend ? SEED : next_row;
  end

  ca_rule_row #(
    .WIDTH (WIDTH),
    .RULE  (RULE)
  ) u_rule (
    .row      (cur_row),
    .next_row (calc_row)
  );

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  // Slot 0 is still being seeded in the first cycle, so bypass it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
    end else if (!rd_ok) begin
      rd_data <= '0;
    end else if (seed_pend) begin
      rd_data <= SEED;
    end else begin
      rd_data <= mem[phys];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      gen_count <= '0;
      head      <= '0;
      filled    <= CW'(1);
      cur_row   <= SEED;
      next_row  <= '0;
      frame_cnt <= '0;
      seed_pend <= 1'b1;
    end else begin
      seed_pend <= 1'b0;
      if (run & frame_tick) begin
        frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
      end
      if (start & busy) begin
        overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          next_row <= calc_row;
          state    <= WRITE;
        end
        WRITE: begin
          cur_row   <= next_row;
          gen_count <= gen_count + 16'd1;
          if (full) begin
            head <= AW'(mod_inc(int'(head), ROWS));
          end else begin
            filled <= filled + 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ca_gen_scheduler.sv
// Randomised bench for ca_gen_scheduler against a generation-history model.
// Honours CA_WRAP_EN in its own edge rule.
module tb_ca_gen_scheduler;

  localparam int         W  = 80;
  localparam int         R  = 60;
  localparam int         F  = 4;
  localparam logic [7:0] RULE_V = 8'd30;
  localparam logic [W-1:0] SEED_V = 80'h1 << 40;
`ifdef CA_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         frame_tick = 1'b0;
  logic         run = 1'b0;
  logic         step = 1'b0;
  logic [5:0]   rd_row = '0;
  logic [W-1:0] rd_data;
  logic         busy;
  logic         overrun;
  logic [15:0]  gen_count;

  logic         e_step = 1'b0;
  logic [5:0]   e_row = 6'd59;
  logic [W-1:0] e_rd;
  logic         e_busy;
  logic         e_ovr;
  logic [15:0]  e_gc;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ca_gen_scheduler #(
    .WIDTH(W), .ROWS(R), .RULE(RULE_V),
    .SEED(SEED_V), .FRAMES_PER_GEN(F)
  ) dut (
    .clk(clk), .rstn(rstn), .frame_tick(frame_tick),
    .run(run), .step(step), .rd_row(rd_row),
    .rd_data(rd_data), .busy(busy), .overrun(overrun),
    .gen_count(gen_count)
  );

  ca_gen_scheduler #(
    .WIDTH(W), .ROWS(R), .RULE(RULE_V),
    .SEED(80'h1), .FRAMES_PER_GEN(F)
  ) u_edge (
    .clk(clk), .rstn(rstn), .frame_tick(1'b0),
    .run(1'b0), .step(e_step), .rd_row(e_row),
    .rd_data(e_rd), .busy(e_busy), .overrun(e_ovr),
    .gen_count(e_gc)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] hist[$];
  int           phase;
  int           fcnt;
  int           gcnt;
  bit           m_ovr;
  logic [W-1:0] m_rd;

  function automatic logic [W-1:0] ca_next(logic [W-1:0] r);
    logic [W-1:0] n;
    logic l, c, rr;
    n = '0;
    for (int i = 0; i < W; i++) begin
      c = r[i];
      if (i == W - 1) l = WRAP ? r[0] : 1'b0;
      else l = r[i+1];
      if (i == 0) rr = WRAP ? r[W-1] : 1'b0;
      else rr = r[i-1];
      n[i] = RULE_V[{l, c, rr}];
    end
    return n;
  endfunction

  function automatic logic [W-1:0] gen_n(int k);
    logic [W-1:0] g;
    g = SEED_V;
    for (int i = 0; i < k; i++) g = ca_next(g);
    return g;
  endfunction

  function automatic logic [W-1:0] m_read(int r);
    int back;
    if (r >= R) return '0;
    back = R - 1 - r;
    if (back >= hist.size()) return '0;
    return hist[hist.size() - 1 - back];
  endfunction

  task automatic m_reset();
    hist.delete();
    hist.push_back(SEED_V);
    phase = 0;
    fcnt  = 0;
    gcnt  = 0;
    m_ovr = 1'b0;
    m_rd  = '0;
  endtask

  task automatic m_step();
    bit st;
    m_rd = m_read(int'(rd_row));
    st = step || (run && frame_tick && fcnt == F - 1);
    if (st && phase != 0) m_ovr = 1'b1;
    if (run && frame_tick) fcnt = (fcnt + 1) % F;
    if (phase == 2) begin
      hist.push_back(ca_next(hist[$]));
      if (hist.size() > R) void'(hist.pop_front());
      gcnt  = (gcnt + 1) % 65536;
      phase = 0;
    end else if (phase == 1) begin
      phase = 2;
    end else if (st) begin
      phase = 1;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) m_reset();
      else m_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("busy", W'(busy), W'(phase != 0));
    chk("overrun", W'(overrun), W'(m_ovr));
    chk("gen_count", W'(gen_count), W'(gcnt[15:0]));
    chk("rd_data", rd_data, m_rd);
  endtask

  logic [W-1:0] e_exp;

  initial begin
    // reset
    repeat (3) cyc();
    chk("rst_rd", rd_data, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_gc", W'(gen_count), '0);
    rstn = 1'b1;
    rd_row = 6'd59;
    cyc();
    chk("seed_row59", rd_data, 80'h1 << 40);
    for (int r = 0; r < 59; r++) begin
      rd_row = 6'(r);
      cyc();
      cyc();
      chk("empty_row", rd_data, '0);
    end

    // single step
    rd_row = 6'd59;
    step = 1'b1;
    e_step = 1'b1;
    cyc();
    step = 1'b0;
    e_step = 1'b0;
    chk("step_busy1", W'(busy), W'(1));
    cyc();
    chk("step_busy2", W'(busy), W'(1));
    cyc();
    chk("step_idle", W'(busy), '0);
    chk("step_gc", W'(gen_count), W'(1));
    cyc();
    chk("gen1", rd_data, 80'h7 << 39);
    e_exp = 80'h3;
    if (WRAP) e_exp[W-1] = 1'b1;
    chk("edge_gen1", e_rd, e_exp);
    chk("edge_gc", W'(e_gc), W'(1));
    chk("edge_ovr", W'(e_ovr), '0);
    chk("edge_busy", W'(e_busy), '0);

    // free run divider
    run = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      repeat (5) cyc();
      chk("div_gc", W'(gen_count), W'(1 + k / 4));
    end
    run = 1'b0;

    // fill past ring depth
    for (int k = 0; k < 62; k++) begin
      step = 1'b1;
      rd_row = 6'($urandom_range(0, 63));
      cyc();
      step = 1'b0;
      repeat (3) cyc();
    end
    chk("gc65", W'(gen_count), W'(65));
    rd_row = 6'd0;
    cyc();
    cyc();
    chk("oldest", rd_data, gen_n(6));
    rd_row = 6'd59;
    cyc();
    cyc();
    chk("newest", rd_data, gen_n(65));
    rd_row = 6'd62;
    cyc();
    cyc();
    chk("oob_row", rd_data, '0);

    // request while busy
    step = 1'b1;
    cyc();
    cyc();
    step = 1'b0;
    chk("ovr_set", W'(overrun), W'(1));
    repeat (4) cyc();
    chk("ovr_gc", W'(gen_count), W'(66));
    chk("ovr_sticky", W'(overrun), W'(1));

    // random traffic
    for (int k = 0; k < 900; k++) begin
      if (k % 50 == 0) run = ($urandom_range(0, 3) != 0);
      frame_tick = ($urandom_range(0, 5) == 0);
      step = ($urandom_range(0, 19) == 0);
      rd_row = 6'($urandom_range(0, 63));
      cyc();
    end
    frame_tick = 1'b0;
    step = 1'b0;
    run = 1'b0;
    repeat (4) cyc();

    // reset in the middle of a write
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    chk("mid_busy", W'(busy), W'(1));
    #2 rstn = 1'b0;
    cyc();
    chk("mid_rst_busy", W'(busy), '0);
    chk("mid_rst_gc", W'(gen_count), '0);
    chk("mid_rst_ovr", W'(overrun), '0);
    rstn = 1'b1;
    rd_row = 6'd59;
    cyc();
    chk("mid_seed", rd_data, 80'h1 << 40);
    rd_row = 6'd58;
    cyc();
    chk("mid_empty", rd_data, '0);
    for (int k = 0; k < 100; k++) begin
      step = ($urandom_range(0, 7) == 0);
      rd_row = 6'($urandom_range(0, 63));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
